coin_qualifier: RTL and testbench
=================================

Name: coin_qualifier

Overview:
Upstream front end of the vending FSM. Synchronises and debounces the two raw coin-slot sensors and classifies each insertion. Emits a single-cycle coin code on the 2-bit coin bus consumed by the vending FSM: 0 = none, 1 = 5-unit, 2 = 10-unit. Rejects invalid or disallowed insertions and flags stuck sensors.

Parameters:
DEB_CYCLES, 4, consecutive synced-high samples required to qualify a coin; also consecutive synced-low samples required to re-arm (legal range 2..15).
STUCK_CYCLES, 64, cycles a sensor may stay high after qualification before a fault is declared (must be greater than DEB_CYCLES).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
sense_5  input  1  raw 5-unit slot sensor; asynchronous to clk
sense_10  input  1  raw 10-unit slot sensor; asynchronous to clk
accept_en  input  1  1 = coins may be accepted; 0 = qualified coins are rejected (vending FSM busy or dispensing)
coin  output  2  registered coin code to the vending FSM; non-zero for exactly one cycle per accepted coin
coin_rej  output  1  registered one-cycle pulse; drives the return-chute gate
fault  output  1  sticky sensor-fault flag

Behaviour:
- Reset (asynchronous, active-high): coin=0, coin_rej=0, fault=0, synchronisers=0, state=IDLE, counter=0.
- Each sensor passes through a 2-flop synchroniser. s5 and s10 denote the synced values. FSM decisions use only s5/s10.
- One counter, width $clog2(STUCK_CYCLES+1), saturating at its maximum.
- All outputs are registered. coin and coin_rej are 0 in every cycle not listed below.
- IDLE: counter=0.
  - Exactly one of s5/s10 high: latch the type, counter=1, go to QUAL.
  - Both high: go to REJECT.
  - Neither high: stay in IDLE.
- QUAL:
  - Latched sensor high and other sensor low: counter+1. When counter reaches DEB_CYCLES, go to EMIT.
  - Latched sensor drops before DEB_CYCLES: treat as a glitch; go to IDLE with no output.
  - Other sensor rises: go to REJECT.
- EMIT (one cycle):
  - accept_en=1: coin=latched code (1 or 2) for one cycle.
  - accept_en=0: coin_rej=1 instead; coin stays 0.
  - accept_en is sampled in the EMIT cycle only.
  - Then go to RELEASE with counter=0.
- REJECT (one cycle): coin_rej=1. Then go to RELEASE with counter=0.
- RELEASE: waits for both sensors low for DEB_CYCLES consecutive samples.
  - Low streak counter restarts on any high sample.
  - A separate elapsed-cycle count runs from RELEASE entry. If it reaches STUCK_CYCLES before re-arm, go to FAULT.
  - On re-arm, go to IDLE.
  - Implementation keeps two counts, or one counter plus a low-streak counter of width 4.
- FAULT: fault=1, coin=0, coin_rej=0, all sensor activity ignored. Exit only by rst.
- Latency: raw sensor rises and is first sampled high at edge E, held clean. coin is non-zero in the cycle following edge E+DEB_CYCLES+2 (2 synchroniser + DEB_CYCLES qualify), for one cycle.
- Minimum spacing between two accepted coins equals the full RELEASE low window. Coins cannot be lost silently: every qualified insertion yields exactly one coin pulse or one coin_rej pulse.
- Reset mid-QUAL or mid-EMIT: no pulse is emitted and the insertion is discarded.
- coin value 3 is never driven.

Optional Feature:
COIN_TALLY_EN
- Defined: adds output ports tally_5[7:0] and tally_10[7:0] and rej_cnt[7:0]. These are saturating counters (stop at 255), reset to 0.
  - tally_5 / tally_10 increment in the cycle coin=1 / coin=2.
  - rej_cnt increments in the cycle coin_rej=1.
- Undefined: ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Package coin_pkg:
  - coin_t codes: COIN_NONE=2'd0, COIN_5=2'd1, COIN_10=2'd2.
  - qual_state_t enum: IDLE, QUAL, EMIT, REJECT, RELEASE, FAULT.
  - Shared by the vending FSM for its coin input.
- Sub-module coin_sync: 2-flop synchroniser with async active-high reset, instantiated once per sensor.

Test Plan:
- DEB_CYCLES=4, accept_en=1; sense_5 high for 10 cycles, then low → coin=1 for exactly one cycle, 6 cycles after first raw-high edge; no coin_rej; returns to IDLE 4 synced-low samples after release.
- sense_10 high for 3 cycles only (glitch) → coin stays 0, coin_rej stays 0, state back to IDLE.
- sense_5 and sense_10 rise on the same edge → coin_rej=1 for one cycle; coin stays 0.
- accept_en=0, valid sense_10 insertion → coin_rej=1 for one cycle, coin=0. Repeat with accept_en=1 → coin=2.
- sense_5 held high 100 cycles with STUCK_CYCLES=64 → coin=1 once, then fault=1 and stays 1 after sensor drops; only rst clears it.
- rst asserted asynchronously mid-QUAL → coin/coin_rej/fault immediately 0. With COIN_TALLY_EN defined: 300 accepted 5-unit coins → tally_5=255.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared coin-bus codes and qualifier state encoding.
// The vending FSM imports coin_t for its coin input.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_5    = 2'd1,
    COIN_10   = 2'd2
  } coin_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUAL    = 3'd1,
    EMIT    = 3'd2,
    REJECT  = 3'd3,
    RELEASE = 3'd4,
    FAULT   = 3'd5
  } qual_state_t;

  localparam int unsigned TallyWidth = 8;

  // Saturating increment used by the optional tally counters.
  function automatic logic [TallyWidth-1:0] sat_inc(input logic [TallyWidth-1:0] v);
    return (v == {TallyWidth{1'b1}}) ? v : v + TallyWidth'(1);
  endfunction

endpackage

// File: rtl/coin_sync.sv
// Two-flop synchroniser for one raw coin-slot sensor.
module coin_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/coin_qualifier.sv
// Coin front end: synchronise, debounce and classify the two slot sensors.
// Define COIN_TALLY_EN to add saturating tally_5/tally_10/rej_cnt counters.
module coin_qualifier
  import coin_pkg::*;
#(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned STUCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sense_5,
  input  logic       sense_10,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic       coin_rej,
  output logic       fault
`ifdef COIN_TALLY_EN
  ,
  output logic [7:0] tally_5,
  output logic [7:0] tally_10,
  output logic [7:0] rej_cnt
`endif
);

  localparam int unsigned CntW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
  localparam logic [CntW-1:0] DebCnt   = CntW'(DEB_CYCLES);
  localparam logic [CntW-1:0] StuckCnt = CntW'(STUCK_CYCLES);
  localparam logic [3:0]      DebLow   = 4'(DEB_CYCLES);

  logic s5;
  logic s10;

  coin_sync u_sync_5 (
    .clk (clk),
    .rst (rst),
    .d   (sense_5),
    .q   (s5)
  );

  coin_sync u_sync_10 (
    .clk (clk),
    .rst (rst),
    .d   (sense_10),
    .q   (s10)
  );

  qual_state_t     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      low_q, low_d;
  coin_t           type_q, type_d;
  coin_t           coin_q, coin_d;
  logic            rej_q, rej_d;
  logic            fault_q, fault_d;

  logic [CntW-1:0] cnt_inc;
  logic [3:0]      low_inc;
  logic            lat_hi;
  logic            oth_hi;
  logic            any_hi;

  always_comb begin
    cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    low_inc = low_q + 4'd1;
    lat_hi  = (type_q == COIN_10) ? s10 : s5;
    oth_hi  = (type_q == COIN_10) ? s5 : s10;
    any_hi  = s5 | s10;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    low_d   = low_q;
    type_d  = type_q;
    coin_d  = COIN_NONE;
    rej_d   = 1'b0;
    fault_d = fault_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        low_d = '0;
        if (s5 && s10) begin
          state_d = REJECT;
        end else if (s5) begin
          type_d  = COIN_5;
          cnt_d   = CntW'(1);
          state_d = QUAL;
        end else if (s10) begin
          type_d  = COIN_10;
          cnt_d   = CntW'(1);
          state_d = QUAL;
        end
      end

      QUAL: begin
        // A second sensor during qualification is treated as a bad insertion.
        if (oth_hi) begin
          state_d = REJECT;
        end else if (!lat_hi) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DebCnt) begin
            state_d = EMIT;
          end
        end
      end

      EMIT: begin
        if (accept_en) begin
          coin_d = type_q;
        end else begin
          rej_d = 1'b1;
        end
        cnt_d   = '0;
        low_d   = '0;
        state_d = RELEASE;
      end

      REJECT: begin
        rej_d   = 1'b1;
        cnt_d   = '0;
        low_d   = '0;
        state_d = RELEASE;
      end

      RELEASE: begin
        // cnt counts elapsed cycles since entry; low counts the clean-low streak.
        cnt_d = cnt_inc;
        low_d = any_hi ? 4'd0 : low_inc;
        if (!any_hi && (low_inc >= DebLow)) begin
          cnt_d   = '0;
          low_d   = '0;
          state_d = IDLE;
        end else if (cnt_inc >= StuckCnt) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end

      FAULT: begin
        fault_d = 1'b1;
      end

      default: begin
        cnt_d   = '0;
        low_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      low_q   <= '0;
      type_q  <= COIN_NONE;
      coin_q  <= COIN_NONE;
      rej_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      low_q   <= low_d;
      type_q  <= type_d;
      coin_q  <= coin_d;
      rej_q   <= rej_d;
      fault_q <= fault_d;
    end
  end

  assign coin     = coin_q;
  assign coin_rej = rej_q;
  assign fault    = fault_q;

`ifdef COIN_TALLY_EN
  logic [7:0] tally_5_q;
  logic [7:0] tally_10_q;
  logic [7:0] rej_cnt_q;

  // Counters follow the registered pulses, so each lands one cycle after its pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally_5_q  <= '0;
      tally_10_q <= '0;
      rej_cnt_q  <= '0;
    end else begin
      if (coin_q == COIN_5) begin
        tally_5_q <= sat_inc(tally_5_q);
      end
      if (coin_q == COIN_10) begin
        tally_10_q <= sat_inc(tally_10_q);
      end
      if (rej_q) begin
        rej_cnt_q <= sat_inc(rej_cnt_q);
      end
    end
  end

  assign tally_5  = tally_5_q;
  assign tally_10 = tally_10_q;
  assign rej_cnt  = rej_cnt_q;
`endif

endmodule

// File: tb/tb_coin_qualifier.sv
// Self-checking bench for coin_qualifier: vector table, scoreboard of expected pulses
// and hand-written sequences for stuck-sensor fault and asynchronous reset.
module tb_coin_qualifier;
  import coin_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       sense_5;
  logic       sense_10;
  logic       accept_en;
  logic [1:0] coin;
  logic       coin_rej;
  logic       fault;
`ifdef COIN_TALLY_EN
  logic [7:0] tally_5;
  logic [7:0] tally_10;
  logic [7:0] rej_cnt;
`endif

  always #5 clk = ~clk;

  coin_qualifier #(
    .DEB_CYCLES   (4),
    .STUCK_CYCLES (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sense_5   (sense_5),
    .sense_10  (sense_10),
    .accept_en (accept_en),
    .coin      (coin),
    .coin_rej  (coin_rej),
    .fault     (fault)
`ifdef COIN_TALLY_EN
    ,
    .tally_5   (tally_5),
    .tally_10  (tally_10),
    .rej_cnt   (rej_cnt)
`endif
  );

  int          checks = 0;
  int          passes = 0;
  int          npulse = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  code;
    logic        rej;
    int unsigned due;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    string      name;
    int         n5;
    int         d10;
    int         n10;
    logic       acc;
    logic [1:0] code;
    logic       rej;
    int         off;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  // Every coin/coin_rej pulse must match the oldest expected entry, value and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (coin != 2'd0 || coin_rej)) begin
      npulse++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {29'd0, coin_rej, coin}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_coin", {30'd0, coin}, {30'd0, e.code});
        chk("pulse_rej", {31'd0, coin_rej}, {31'd0, e.rej});
        chk("pulse_time", cyc, e.due);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int len;
    int p0;
    int exp_n;
    len   = ((v.n5 > v.d10 + v.n10) ? v.n5 : v.d10 + v.n10) + 16;
    p0    = npulse;
    exp_n = (v.code != 2'd0 || v.rej) ? 1 : 0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      sense_5   = (c < v.n5);
      sense_10  = (c >= v.d10) && (c < v.d10 + v.n10);
      accept_en = v.acc;
      if (c == 0 && exp_n == 1) sb.push_back('{v.code, v.rej, cyc + v.off});
    end
    @(posedge clk);
    #1;
    chk({v.name, "_pulses"}, npulse - p0, exp_n);
    chk({v.name, "_pending"}, sb.size(), 0);
    chk({v.name, "_fault"}, {31'd0, fault}, 32'd0);
    sb.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      sense_5  = 1'b0;
      sense_10 = 1'b0;
    end
  endtask

  initial begin
    int unsigned k;
    int          p0;
    vec_t        tv;

    vecs[0] = '{"s5_clean",        10, 0, 0,  1'b1, 2'd1, 1'b0, 7};
    vecs[1] = '{"s10_glitch",      0,  0, 3,  1'b1, 2'd0, 1'b0, 0};
    vecs[2] = '{"both_same_edge",  10, 0, 10, 1'b1, 2'd0, 1'b1, 4};
    vecs[3] = '{"s10_busy",        0,  0, 10, 1'b0, 2'd0, 1'b1, 7};
    vecs[4] = '{"s10_accept",      0,  0, 10, 1'b1, 2'd2, 1'b0, 7};
    vecs[5] = '{"s10_during_qual", 10, 2, 5,  1'b1, 2'd0, 1'b1, 6};
    vecs[6] = '{"s5_min_width",    4,  0, 0,  1'b1, 2'd1, 1'b0, 7};
    vecs[7] = '{"s5_short",        3,  0, 0,  1'b0, 2'd0, 1'b0, 0};

    rst       = 1'b1;
    sense_5   = 1'b0;
    sense_10  = 1'b0;
    accept_en = 1'b1;
    #1;
    chk("reset_coin", {30'd0, coin}, 32'd0);
    chk("reset_rej", {31'd0, coin_rej}, 32'd0);
    chk("reset_fault", {31'd0, fault}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset mid-QUAL: outputs clear at once and the insertion is discarded.
    p0 = npulse;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sense_5 = 1'b1;
    end
    #2;
    rst     = 1'b1;
    sense_5 = 1'b0;
    #1;
    chk("rst_qual_coin", {30'd0, coin}, 32'd0);
    chk("rst_qual_rej", {31'd0, coin_rej}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(20);
    chk("rst_qual_no_pulse", npulse - p0, 0);

    // Reset while in EMIT: no pulse may follow.
    p0 = npulse;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      sense_10 = 1'b1;
    end
    #2;
    rst      = 1'b1;
    sense_10 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(20);
    chk("rst_emit_no_pulse", npulse - p0, 0);

    // Stuck sensor: one coin, then sticky fault 64 cycles after RELEASE entry.
    p0 = npulse;
    k  = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      sense_5   = 1'b1;
      accept_en = 1'b1;
      if (c == 0) begin
        k = cyc;
        sb.push_back('{2'd1, 1'b0, cyc + 7});
      end
      if (c == 70) chk("stuck_fault_early", {31'd0, fault}, 32'd0);
      if (c == 71) chk("stuck_fault_set", {31'd0, fault}, 32'd1);
    end
    idle_cycles(20);
    chk("stuck_fault_held", {31'd0, fault}, 32'd1);
    tv = '{"ignored_in_fault", 0, 0, 10, 1'b1, 2'd0, 1'b0, 0};
    for (int c = 0; c < 26; c++) begin
      @(negedge clk);
      sense_10 = (c < tv.n10);
    end
    chk("stuck_one_coin", npulse - p0, 1);
    chk("fault_after_activity", {31'd0, fault}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("fault_async_clear", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);

    // Re-armed after reset: a normal coin goes through.
    run_vec(vecs[0]);

`ifdef COIN_TALLY_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(4);
    for (int i = 0; i < 300; i++) run_vec(vecs[6]);
    idle_cycles(4);
    chk("tally_5_sat", {24'd0, tally_5}, 32'd255);
    chk("tally_10_zero", {24'd0, tally_10}, 32'd0);
    chk("rej_cnt_zero", {24'd0, rej_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
